dsp_arbiter: RTL

DSP_ARBITER -- requirements
Module: dsp_arbiter

---
 rtl/dsp_arbiter_pkg.sv | 15 +
 rtl/dsp_mac_core.sv | 64 ++++++
 rtl/dsp_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/dsp_arbiter_pkg.sv
// Shared constants for the arbitrated multiply-accumulate block: op encoding,
// operand widths and pipeline depth.
package dsp_arbiter_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int OPND_W   = 18;
  localparam int ACC_W    = 48;
  localparam int PROD_W   = 2 * OPND_W;
  localparam int PIPE_LAT = 2;

endpackage

// File: rtl/dsp_mac_core.sv
// Two-stage pre-add/multiply/accumulate datapath: stage 1 captures operands,
// stage 2 captures the finished result.
module dsp_mac_core
  import dsp_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic              i_advance,
  input  logic              i_op,
  input  logic [OPND_W-1:0] i_a,
  input  logic [OPND_W-1:0] i_b,
  input  logic [OPND_W-1:0] i_d,
  input  logic [ACC_W-1:0]  i_c,
  output logic [ACC_W-1:0]  o_p
);

  op_e               r_op;
  logic [OPND_W-1:0] r_a;
  logic [OPND_W-1:0] r_b;
  logic [OPND_W-1:0] r_d;
  logic [ACC_W-1:0]  r_c;
  logic [ACC_W-1:0]  r_p;

  logic [OPND_W-1:0] w_pre;
  logic [PROD_W-1:0] w_prod;
  logic [ACC_W-1:0]  w_prod_ext;
  logic [ACC_W-1:0]  w_p;

  // Pre-adder and accumulator wrap modulo their widths; the op selects
  // add or subtract for both.
  always_comb begin
    w_pre      = (r_op == OP_SUB) ? (r_d - r_b) : (r_d + r_b);
    w_prod     = w_pre * r_a;
    w_prod_ext = {{(ACC_W-PROD_W){1'b0}}, w_prod};
    w_p        = (r_op == OP_SUB) ? (w_prod_ext - r_c) : (w_prod_ext + r_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op <= OP_ADD;
      r_a  <= '0;
      r_b  <= '0;
      r_d  <= '0;
      r_c  <= '0;
      r_p  <= '0;
    end else begin
      if (i_load) begin
        r_op <= op_e'(i_op);
        r_a  <= i_a;
        r_b  <= i_b;
        r_d  <= i_d;
        r_c  <= i_c;
      end
      // Output only moves when a real operation advances, so it holds otherwise.
      if (i_advance) begin
        r_p <= w_p;
      end
    end
  end

  assign o_p = r_p;

endmodule

// File: rtl/dsp_arbiter.sv
// Round-robin arbiter feeding N_REQ requesters into one shared MAC pipeline,
// tracking valid and requester id alongside the datapath.
module dsp_arbiter
  import dsp_arbiter_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ-1:0]        req_op,
  input  logic [N_REQ*OPND_W-1:0] req_a,
  input  logic [N_REQ*OPND_W-1:0] req_b,
  input  logic [N_REQ*OPND_W-1:0] req_d,
  input  logic [N_REQ*ACC_W-1:0]  req_c,
  output logic                    res_valid,
  output logic [IDW-1:0]          res_id,
  output logic [ACC_W-1:0]        res_p,
  output logic                    busy
);

  logic [IDW-1:0] r_last_grant;
  logic           r_s1_valid;
  logic [IDW-1:0] r_s1_id;
  logic           r_s2_valid;
  logic [IDW-1:0] r_res_id;

  logic              w_found;
  logic [IDW-1:0]    w_grant_idx;
  logic              w_accept;
  logic              w_op;
  logic [OPND_W-1:0] w_a;
  logic [OPND_W-1:0] w_b;
  logic [OPND_W-1:0] w_d;
  logic [ACC_W-1:0]  w_c;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    int cand;
    cand        = 0;
    w_found     = 1'b0;
    w_grant_idx = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = (int'(r_last_grant) + k) % N_REQ;
      if (!w_found && req_valid[cand]) begin
        w_found     = 1'b1;
        w_grant_idx = IDW'(cand);
      end
    end
  end

  assign w_accept  = rst_n && en && w_found;
  assign req_ready = w_accept ? (N_REQ'(1) << w_grant_idx) : '0;

  assign w_op = req_op[w_grant_idx];
  assign w_a  = req_a[w_grant_idx*OPND_W +: OPND_W];
  assign w_b  = req_b[w_grant_idx*OPND_W +: OPND_W];
  assign w_d  = req_d[w_grant_idx*OPND_W +: OPND_W];
  assign w_c  = req_c[w_grant_idx*ACC_W +: ACC_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= IDW'(N_REQ - 1);
      r_s1_valid   <= 1'b0;
      r_s1_id      <= '0;
      r_s2_valid   <= 1'b0;
      r_res_id     <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_id      <= w_grant_idx;
        r_last_grant <= w_grant_idx;
      end
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res_id <= r_s1_id;
      end
    end
  end

  dsp_mac_core u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (w_accept),
    .i_advance (r_s1_valid),
    .i_op      (w_op),
    .i_a       (w_a),
    .i_b       (w_b),
    .i_d       (w_d),
    .i_c       (w_c),
    .o_p       (res_p)
  );

  assign res_valid = r_s2_valid;
  assign res_id    = r_res_id;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule
